pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Parametrised, pipelined adder/subtractor. It is the registered, streaming successor to the team's combinational half adder. Operands are split into CHUNK-bit slices, and the carry ripples one slice per clock, so WIDTH can grow without lengthening the critical path. A valid/ready handshake on both sides lets it sit directly in datapath streams, and it produces sum, carry/no-borrow and signed-overflow flags.

## Interface
- WIDTH, 8: operand and sum width in bits; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4: slice width per pipeline stage. STAGES = WIDTH/CHUNK.
- CLK  input  1  single clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A (unsigned or two's complement).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; used only when Sub=0.
- Sub  input  1  mode: 0 = A+B+Cin, 1 = A−B (internally A + ~B + 1; Cin ignored).
- In_valid  input  1  A/B/Cin/Sub are valid this cycle.
- In_ready  output  1  block accepts a transfer this cycle.
- Out_valid  output  1  Sum/Carry/Overflow are valid.
- Out_ready  input  1  downstream accepts the result this cycle.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Carry  output  1  add: carry-out of MSB; sub: 1 = no borrow (A ≥ B unsigned).
- Overflow  output  1  signed overflow of the operation.

## Operation
- Advance condition: adv = ~Out_valid | Out_ready. The whole pipeline moves together on adv and holds entirely on ~adv.
- In_ready = adv, combinational from Out_valid and Out_ready.
- Acceptance: a transfer occurs when In_valid & In_ready.
- Stage 1 registers:
  - the full A and B^{WIDTH{Sub}};
  - the slice-0 sum of CHUNK bits;
  - the slice-0 carry, with carry-in = Sub ? 1 : Cin;
  - a per-stage valid bit.
- Stage k (2..STAGES): adds slice k−1 using the carry from stage k−1, and forwards the already-computed lower sum bits plus the remaining upper operand slices.
- Final stage outputs:
  - Sum is all slices concatenated.
  - Carry is the MSB slice carry-out.
  - Overflow = (A[MSB] == B'[MSB]) & (Sum[MSB] != A[MSB]), where B' is the post-inversion B.
- Bubbles: when adv is high and no transfer occurs, a bubble (valid=0) enters. Bubbles propagate and are absorbed normally.
- Data registers of invalid stages may hold stale values. Outputs are qualified only by Out_valid.
- Ordering: results leave in acceptance order. No reordering, no drop, no duplication.
- STAGES=1 (CHUNK=WIDTH) is legal: a single registered stage.

## Timing
- Reset (asynchronous assert): every stage valid=0; Out_valid=0, Sum=0, Carry=0, Overflow=0.
- In_ready is 1 during and after reset, because Out_valid=0.
- Reset deassertion: the first acceptance is possible on the first rising CLK edge after RST falls.
- Reset mid-operation: all in-flight results are discarded. No partial result appears after reset.
- Latency: with Out_ready held 1, an operand accepted at edge n gives Out_valid=1 after edge n+STAGES−1, i.e. visible in the cycle following that edge. That is STAGES cycles of latency.
- Throughput: one result per cycle with Out_ready=1.
- Stall: Out_valid=1 & Out_ready=0 forces In_ready=0. All stages hold and Sum/Carry/Overflow stay stable until the handshake completes.
- Simultaneous Out_valid&Out_ready and In_valid: the output retires and the input is accepted in the same edge. There is no bubble.
- In_ready is combinational from Out_ready, by design.
- Wrap-around: Sum wraps modulo 2^WIDTH. Carry and Overflow report the wrap; there is no saturation.

## Test plan
Run with WIDTH=8, CHUNK=4 (STAGES=2) unless stated. Check every result against a reference model of A+B+Cin and A−B.
- Cross-slice carry: A=0x0F, B=0x01, Sub=0, Cin=0 -> Sum=0x10, Carry=0, Overflow=0, with Out_valid exactly 2 cycles after acceptance.
- Unsigned wrap and signed overflow:
  - 0xFF+0x01 -> Sum=0x00, Carry=1, Ov=0.
  - 0x7F+0x01 -> Sum=0x80, Carry=0, Ov=1.
  - 0x00+0x00 with Cin=1 -> Sum=0x01.
- Subtract:
  - 0x05−0x07 -> Sum=0xFE, Carry=0, Ov=0.
  - 0x80−0x01 -> Sum=0x7F, Carry=1, Ov=1.
  - 0x09−0x09 with Cin=1 -> Sum=0x00, Carry=1 (Cin ignored).
- Backpressure: stream 5 back-to-back adds (0x10+k, k=0..4), with Out_ready=0 for 3 cycles mid-stream:
  - In_ready=0 while stalled;
  - outputs stay stable while stalled;
  - 5 results come out in order, none lost or repeated.
- Reset mid-flight: accept 2 operands, assert RST asynchronously between edges -> Out_valid, Sum, Carry and Overflow go to 0 immediately. After release, one new add 0x03+0x04 -> 0x07 is the only result.
- Parameter sweep: WIDTH=16 with CHUNK=4 (latency 4) and with CHUNK=16 (latency 1). Send 1000 random operands with random Out_ready -> all match the model; latency is exact when there is no stall.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub_if
// Stream bundle for the pipelined adder/subtractor.
//   Request side : a, b, cin, sub, in_valid   (upstream -> adder)
//                  in_ready                   (adder -> upstream)
//   Result side  : sum, carry, overflow, out_valid (adder -> downstream)
//                  out_ready                  (downstream -> adder)
// Modports:
//   master - the environment around the adder (drives operands, takes results)
//   slave  - the adder itself
// -----------------------------------------------------------------------------
interface pipelined_add_sub_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub
// Streaming adder/subtractor whose carry ripples one CHUNK-bit slice per clock,
// so the critical path stays one CHUNK-bit add regardless of WIDTH.
//   sub=0 : sum = a + b + cin
//   sub=1 : sum = a - b  (computed as a + ~b + 1, cin ignored)
// carry is the MSB carry-out (for subtraction 1 means "no borrow", a >= b
// unsigned); overflow flags two's-complement overflow.
//
// Parameters:
//   WIDTH - operand/result width, a multiple of CHUNK and >= CHUNK
//   CHUNK - slice width handled per stage; STAGES = WIDTH/CHUNK
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset; discards everything in flight
//   bus  - pipelined_add_sub_if.slave (operand stream in, result stream out)
//
// The whole pipeline advances together whenever the output register is empty
// or being drained (adv); otherwise every stage holds. in_ready is adv itself,
// so it is combinational from out_ready.
// -----------------------------------------------------------------------------
module pipelined_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_add_sub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Per-stage state. Stage s has resolved slices 0..s of the sum; a_q/b_q carry
  // the operands forward (b already conditionally inverted) so the remaining
  // upper slices can be added later.
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q,     a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q,     b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q,   sum_d;
  logic [STAGES-1:0]            carry_q, carry_d;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             carry_in;
  logic [CHUNK:0]   slice0;
  logic [CHUNK:0]   slice_k;

  assign adv = ~valid_q[LAST] | bus.out_ready;

  always_comb begin
    // Default: every stage holds.
    valid_d  = valid_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    slice_k  = '0;

    // Subtraction is a + ~b + 1: invert b and force the slice-0 carry-in.
    b_eff    = bus.b ^ {WIDTH{bus.sub}};
    carry_in = bus.sub ? 1'b1 : bus.cin;
    slice0   = {1'b0, bus.a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, carry_in};

    if (adv) begin
      // Entry stage: a cycle without a transfer injects a bubble.
      valid_d[0]            = bus.in_valid;
      a_d[0]                = bus.a;
      b_d[0]                = b_eff;
      sum_d[0]              = '0;
      sum_d[0][CHUNK-1:0]   = slice0[CHUNK-1:0];
      carry_d[0]            = slice0[CHUNK];

      // Stage s resolves slice s from the carry left by stage s-1 and keeps
      // the lower slices already computed.
      for (int s = 1; s < STAGES; s++) begin
        slice_k = {1'b0, a_q[s-1][s*CHUNK +: CHUNK]}
                + {1'b0, b_q[s-1][s*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_q[s-1]};
        valid_d[s]                 = valid_q[s-1];
        a_d[s]                     = a_q[s-1];
        b_d[s]                     = b_q[s-1];
        sum_d[s]                   = sum_q[s-1];
        sum_d[s][s*CHUNK +: CHUNK] = slice_k[CHUNK-1:0];
        carry_d[s]                 = slice_k[CHUNK];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.carry     = carry_q[LAST];
  // Overflow: operands (with b post-inversion) share a sign and the result
  // sign differs. All three terms are zero in reset, so overflow resets to 0.
  assign bus.overflow  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                         (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_add_sub
// Three instances (8/4, 16/4, 16/16) share one clock and reset. A single
// compare process checks every retiring result against an arithmetic model
// queue, plus handshake and stall-stability rules. Directed cases on the 8/4
// instance pin the model to literal values.
// -----------------------------------------------------------------------------
module tb_pipelined_add_sub;
  localparam int NCFG = 3;
  localparam int CFG_W [NCFG] = '{8, 16, 16};
  localparam int CFG_C [NCFG] = '{4, 4, 16};

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ov;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic [15:0] drv_a    [NCFG];
  logic [15:0] drv_b    [NCFG];
  logic        drv_cin  [NCFG];
  logic        drv_sub  [NCFG];
  logic        drv_iv   [NCFG];
  logic        drv_ordy [NCFG];

  logic [15:0] mon_sum   [NCFG];
  logic        mon_carry [NCFG];
  logic        mon_ov    [NCFG];
  logic        mon_ovld  [NCFG];
  logic        mon_irdy  [NCFG];

  exp_t        exp_q [NCFG][$];
  logic [7:0]  ret_log[$];
  bit          lat_exact [NCFG];
  int          acc_cnt   [NCFG];
  bit          held_v    [NCFG];
  logic [15:0] held_sum  [NCFG];
  logic        held_c    [NCFG];
  logic        held_o    [NCFG];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = CFG_W[gi];
    localparam int C = CFG_C[gi];
    pipelined_add_sub_if #(.WIDTH(W)) bus ();
    pipelined_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.a         = drv_a[gi][W-1:0];
    assign bus.b         = drv_b[gi][W-1:0];
    assign bus.cin       = drv_cin[gi];
    assign bus.sub       = drv_sub[gi];
    assign bus.in_valid  = drv_iv[gi];
    assign bus.out_ready = drv_ordy[gi];
    assign mon_sum[gi]   = 16'(bus.sum);
    assign mon_carry[gi] = bus.carry;
    assign mon_ov[gi]    = bus.overflow;
    assign mon_ovld[gi]  = bus.out_valid;
    assign mon_irdy[gi]  = bus.in_ready;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, signed overflow from the true signed
  // result falling outside the representable range.
  function automatic exp_t ref_calc(input int w, input logic [15:0] a_in,
                                    input logic [15:0] b_in, input logic cin,
                                    input logic sub);
    exp_t   r;
    longint modv, half, a, b, full, sa, sb, sr;
    modv = longint'(1) << w;
    half = modv / 2;
    a    = longint'(a_in) % modv;
    b    = longint'(b_in) % modv;
    sa   = (a >= half) ? a - modv : a;
    sb   = (b >= half) ? b - modv : b;
    if (!sub) begin
      full    = a + b + longint'(cin);
      r.carry = (full >= modv);
      sr      = sa + sb + longint'(cin);
    end else begin
      full    = a - b + modv;
      r.carry = (a >= b);
      sr      = sa - sb;
    end
    r.sum = 16'(full % modv);
    r.ov  = (sr >= half) || (sr < -half);
    r.acc = 0;
    return r;
  endfunction

  // Compare process: handshake rule, stall stability, in-order results.
  always @(negedge clk) begin
    exp_t e;
    int   stg;
    for (int g = 0; g < NCFG; g++) begin
      stg = CFG_W[g] / CFG_C[g];
      if (rst) begin
        exp_q[g].delete();
        held_v[g] = 1'b0;
      end else begin
        chk($sformatf("cfg%0d in_ready", g), mon_irdy[g], !mon_ovld[g] || drv_ordy[g]);
        if (held_v[g]) begin
          chk($sformatf("cfg%0d stall valid", g), mon_ovld[g], 1);
          chk($sformatf("cfg%0d stall sum", g), mon_sum[g], held_sum[g]);
          chk($sformatf("cfg%0d stall carry", g), mon_carry[g], held_c[g]);
          chk($sformatf("cfg%0d stall ov", g), mon_ov[g], held_o[g]);
        end
        held_v[g]   = mon_ovld[g] && !drv_ordy[g];
        held_sum[g] = mon_sum[g];
        held_c[g]   = mon_carry[g];
        held_o[g]   = mon_ov[g];
        if (mon_ovld[g] && drv_ordy[g]) begin
          if (exp_q[g].size() == 0) begin
            chk($sformatf("cfg%0d unexpected result queue", g), exp_q[g].size(), 1);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("cfg%0d sum", g), mon_sum[g], e.sum);
            chk($sformatf("cfg%0d carry", g), mon_carry[g], e.carry);
            chk($sformatf("cfg%0d overflow", g), mon_ov[g], e.ov);
            if (lat_exact[g])
              chk($sformatf("cfg%0d latency", g), cyc - e.acc, stg - 1);
            else
              chk($sformatf("cfg%0d latency min", g), (cyc - e.acc) >= (stg - 1), 1);
            if (g == 0) ret_log.push_back(mon_sum[0][7:0]);
            $display("cfg%0d result sum=0x%0h carry=%0b ov=%0b", g, mon_sum[g], mon_carry[g], mon_ov[g]);
          end
        end
        if (drv_iv[g] && mon_irdy[g]) begin
          e     = ref_calc(CFG_W[g], drv_a[g], drv_b[g], drv_cin[g], drv_sub[g]);
          e.acc = cyc + 1;
          exp_q[g].push_back(e);
          acc_cnt[g]++;
        end
      end
    end
  end

  // One operation on the 8/4 instance with literal expectations and the
  // exact two-cycle appearance.
  task automatic run_dir(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic [7:0] es,
                         input logic ec, input logic eo);
    exp_t m;
    m = ref_calc(8, {8'h00, a}, {8'h00, b}, cin, sub);
    chk({name, " model sum"}, m.sum, es);
    chk({name, " model carry"}, m.carry, ec);
    chk({name, " model ov"}, m.ov, eo);
    @(posedge clk); #1;
    drv_a[0] = {8'h00, a}; drv_b[0] = {8'h00, b};
    drv_cin[0] = cin; drv_sub[0] = sub; drv_iv[0] = 1'b1; drv_ordy[0] = 1'b1;
    @(posedge clk); #1;
    drv_iv[0] = 1'b0;
    chk({name, " early valid"}, mon_ovld[0], 0);
    @(posedge clk); #1;
    chk({name, " valid"}, mon_ovld[0], 1);
    chk({name, " sum"}, mon_sum[0], es);
    chk({name, " carry"}, mon_carry[0], ec);
    chk({name, " ov"}, mon_ov[0], eo);
  endtask

  task automatic drive_random(input int g, input bit ordy_rand);
    logic [15:0] mask;
    mask = 16'((32'd1 << CFG_W[g]) - 1);
    drv_iv[g]   = ($urandom_range(0, 3) != 0) && (acc_cnt[g] < 1000 || !ordy_rand);
    drv_ordy[g] = ordy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    drv_a[g]    = 16'($urandom) & mask;
    drv_b[g]    = 16'($urandom) & mask;
    if ($urandom_range(0, 7) == 0) drv_a[g] = ($urandom_range(0, 1) != 0) ? mask : (mask ^ (mask >> 1));
    if ($urandom_range(0, 7) == 0) drv_b[g] = ($urandom_range(0, 1) != 0) ? mask : 16'h0000;
    drv_cin[g]  = 1'($urandom_range(0, 1));
    drv_sub[g]  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int k;
    rst = 1'b1;
    for (int g = 0; g < NCFG; g++) begin
      drv_a[g] = '0; drv_b[g] = '0; drv_cin[g] = 0; drv_sub[g] = 0;
      drv_iv[g] = 0; drv_ordy[g] = 1; lat_exact[g] = 1; acc_cnt[g] = 0; held_v[g] = 0;
    end
    #7;
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("cfg%0d reset out_valid", g), mon_ovld[g], 0);
      chk($sformatf("cfg%0d reset sum", g), mon_sum[g], 0);
      chk($sformatf("cfg%0d reset carry", g), mon_carry[g], 0);
      chk($sformatf("cfg%0d reset ov", g), mon_ov[g], 0);
      chk($sformatf("cfg%0d reset in_ready", g), mon_irdy[g], 1);
    end
    @(negedge clk); #2 rst = 1'b0;

    run_dir("cross-slice", 8'h0F, 8'h01, 0, 0, 8'h10, 0, 0);
    run_dir("wrap ff+01",  8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    run_dir("ovf 7f+01",   8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    run_dir("cin 00+00",   8'h00, 8'h00, 1, 0, 8'h01, 0, 0);
    run_dir("sub 05-07",   8'h05, 8'h07, 0, 1, 8'hFE, 0, 0);
    run_dir("sub 80-01",   8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
    run_dir("sub 09-09",   8'h09, 8'h09, 1, 1, 8'h00, 1, 0);
    run_dir("sub 00-80",   8'h00, 8'h80, 0, 1, 8'h80, 0, 1);
    @(posedge clk); #1;

    // Backpressure: five back-to-back adds with a 3-cycle output stall.
    ret_log.delete();
    lat_exact[0] = 0;
    k = 0;
    for (int t = 0; t < 40 && (k < 5 || exp_q[0].size() > 0 || mon_ovld[0]); t++) begin
      @(posedge clk); #1;
      drv_ordy[0] = !(t >= 3 && t < 6);
      drv_iv[0]   = (k < 5);
      drv_a[0]    = 16'(16'h10 + k);
      drv_b[0]    = 16'(k);
      drv_cin[0]  = 0; drv_sub[0] = 0;
      #1;
      if (t >= 3 && t < 6 && mon_ovld[0]) chk("bp in_ready stalled", mon_irdy[0], 0);
      if (drv_iv[0] && mon_irdy[0]) k++;
    end
    drv_iv[0] = 0; drv_ordy[0] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp accepted", k, 5);
    chk("bp result count", ret_log.size(), 5);
    for (int i = 0; i < 5 && i < ret_log.size(); i++)
      chk($sformatf("bp order %0d", i), ret_log[i], 8'h10 + 2 * i);
    lat_exact[0] = 1;

    // Reset mid-flight.
    @(posedge clk); #1;
    drv_a[0] = 16'h7F; drv_b[0] = 16'h01; drv_iv[0] = 1; drv_ordy[0] = 1;
    @(posedge clk); #1;
    drv_a[0] = 16'hFF;
    @(posedge clk); #1;
    drv_iv[0] = 0;
    chk("pre-reset out_valid", mon_ovld[0], 1);
    chk("pre-reset sum", mon_sum[0], 16'h80);
    #2 rst = 1'b1;
    #1;
    chk("async reset out_valid", mon_ovld[0], 0);
    chk("async reset sum", mon_sum[0], 0);
    chk("async reset carry", mon_carry[0], 0);
    chk("async reset ov", mon_ov[0], 0);
    chk("async reset in_ready", mon_irdy[0], 1);
    @(posedge clk); #3 rst = 1'b0;
    ret_log.delete();
    @(posedge clk); #1;
    drv_a[0] = 16'h03; drv_b[0] = 16'h04; drv_iv[0] = 1;
    @(posedge clk); #1;
    drv_iv[0] = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("post-reset result count", ret_log.size(), 1);
    if (ret_log.size() > 0) chk("post-reset sum", ret_log[0], 8'h07);

    // Random, no backpressure: latency must be exact.
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NCFG; g++) drive_random(g, 1'b0);
    end
    @(posedge clk); #1;
    for (int g = 0; g < NCFG; g++) drv_iv[g] = 0;
    repeat (8) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("cfg%0d drain1", g), exp_q[g].size(), 0);
      lat_exact[g] = 0;
      acc_cnt[g]   = 0;
    end

    // Random with random out_ready until 1000 operands per instance.
    for (int t = 0; t < 10000 && (acc_cnt[0] < 1000 || acc_cnt[1] < 1000 || acc_cnt[2] < 1000); t++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NCFG; g++) drive_random(g, 1'b1);
    end
    @(posedge clk); #1;
    for (int g = 0; g < NCFG; g++) begin
      drv_iv[g] = 0; drv_ordy[g] = 1;
    end
    repeat (10) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("cfg%0d operand count", g), acc_cnt[g] >= 1000, 1);
      chk($sformatf("cfg%0d drain2", g), exp_q[g].size(), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
